// File: rtl/sram_track_pkg.sv
// Shared types, default geometry and the mix arithmetic for the two-track SRAM scheduler.
// Build option MIX_SAT_EN selects a saturating mix instead of the averaging mix.
package sram_track_pkg;

    localparam int unsigned SAMPLE_W        = 16;
    localparam int unsigned TRACK_LEN_DEF   = 128000;
    localparam int unsigned TRACK1_BASE_DEF = 0;
    localparam int unsigned TRACK2_BASE_DEF = 128000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REC_WR,
        ST_PLAY_RD,
        ST_MIX_RD1,
        ST_MIX_RD2,
        ST_MIX_WR
    } state_e;

    function automatic logic [SAMPLE_W-1:0] mix_sample(input logic [SAMPLE_W-1:0] a,
                                                       input logic [SAMPLE_W-1:0] b);
        logic signed [SAMPLE_W:0] sum;
        sum = $signed({a[SAMPLE_W-1], a}) + $signed({b[SAMPLE_W-1], b});
`ifdef MIX_SAT_EN
        // The 17-bit sum overflows 16 bits exactly when its two top bits disagree.
        if (sum[SAMPLE_W] != sum[SAMPLE_W-1])
            return sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        return sum[SAMPLE_W-1:0];
`else
        sum = sum >>> 1;
        return sum[SAMPLE_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/sram_track_scheduler_counter.sv
// Track pointer: up-counter with enable and synchronous clear, wrapping at WRAP-1 back to zero.
module sram_wrap_counter
    import sram_track_pkg::*;
#(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned WRAP  = TRACK_LEN_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = (cnt_q == WIDTH'(WRAP - 1)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sram_track_scheduler.sv
// Single-port SRAM access sequencer for record, playback and the offline two-track mix.
// Define MIX_SAT_EN to make the mix saturate instead of average.
module sram_track_scheduler
    import sram_track_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned DATA_W      = SAMPLE_W,
    parameter int unsigned TRACK_LEN   = TRACK_LEN_DEF,
    parameter int unsigned TRACK1_BASE = TRACK1_BASE_DEF,
    parameter int unsigned TRACK2_BASE = TRACK2_BASE_DEF,
    parameter int unsigned ACC_CYC     = 3
) (
    input  logic              clk,
    input  logic              AUD_DACLRCK,
    input  logic              frame_tick,
    input  logic              rec_en,
    input  logic              rec_sel,
    input  logic [DATA_W-1:0] rec_data,
    input  logic              play_en,
    input  logic              play_sel,
    output logic [DATA_W-1:0] play_data,
    output logic              play_valid,
    input  logic              mix_start,
    output logic              mix_busy,
    output logic              mix_done,
    output logic              overrun,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam int unsigned      CYC_W    = $clog2(ACC_CYC);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(ACC_CYC - 1);
    localparam logic [CYC_W-1:0] WE_LAST  = CYC_W'(ACC_CYC - 2);

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [ADDR_W-1:0]  rec_ptr, play_ptr, mix_idx;
    logic [DATA_W-1:0]  a_q, rd_q;
    logic               rd_pend_q;
    logic               last_c, rec_inc, play_inc, mix_inc, mix_accept, mix_last;
    logic [ADDR_W-1:0]  rec_addr, play_addr, mix1_addr, mix2_addr;

    assign last_c     = (cyc_q == CYC_LAST);
    assign rec_inc    = (state_q == ST_REC_WR) && last_c;
    assign play_inc   = (state_q == ST_PLAY_RD) && last_c;
    assign mix_inc    = (state_q == ST_MIX_WR) && last_c;
    assign mix_accept = (state_q == ST_IDLE) && mix_start && !mix_busy;
    assign mix_last   = (mix_idx == ADDR_W'(TRACK_LEN - 1));

    assign rec_addr  = (rec_sel ? ADDR_W'(TRACK2_BASE) : ADDR_W'(TRACK1_BASE)) + rec_ptr;
    assign play_addr = (play_sel ? ADDR_W'(TRACK2_BASE) : ADDR_W'(TRACK1_BASE)) + play_ptr;
    assign mix1_addr = ADDR_W'(TRACK1_BASE) + mix_idx;
    assign mix2_addr = ADDR_W'(TRACK2_BASE) + mix_idx;

    sram_wrap_counter #(.WIDTH(ADDR_W), .WRAP(TRACK_LEN)) u_rec_ptr (
        .clk_i(clk), .rst_i(AUD_DACLRCK), .clr_i(1'b0), .en_i(rec_inc), .cnt_o(rec_ptr)
    );
    sram_wrap_counter #(.WIDTH(ADDR_W), .WRAP(TRACK_LEN)) u_play_ptr (
        .clk_i(clk), .rst_i(AUD_DACLRCK), .clr_i(1'b0), .en_i(play_inc), .cnt_o(play_ptr)
    );
    sram_wrap_counter #(.WIDTH(ADDR_W), .WRAP(TRACK_LEN)) u_mix_idx (
        .clk_i(clk), .rst_i(AUD_DACLRCK), .clr_i(mix_accept), .en_i(mix_inc), .cnt_o(mix_idx)
    );

    always_comb begin
        state_d = state_q;
        cyc_d   = last_c ? '0 : cyc_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                cyc_d = '0;
                if (frame_tick) begin
                    if (mix_busy)     state_d = ST_MIX_RD1;
                    else if (rec_en)  state_d = ST_REC_WR;
                    else if (play_en) state_d = ST_PLAY_RD;
                end
            end
            ST_REC_WR:  if (last_c) state_d = (play_en && !mix_busy) ? ST_PLAY_RD : ST_IDLE;
            ST_PLAY_RD: if (last_c) state_d = ST_IDLE;
            ST_MIX_RD1: if (last_c) state_d = ST_MIX_RD2;
            ST_MIX_RD2: if (last_c) state_d = ST_MIX_WR;
            ST_MIX_WR:  if (last_c) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are derived from the upcoming state/cycle so they are registered yet aligned.
    always_ff @(posedge clk or posedge AUD_DACLRCK) begin
        if (AUD_DACLRCK) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            a_q         <= '0;
            rd_q        <= '0;
            rd_pend_q   <= 1'b0;
            play_data   <= '0;
            play_valid  <= 1'b0;
            mix_busy    <= 1'b0;
            mix_done    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            sram_oe_n  <= !(state_d inside {ST_PLAY_RD, ST_MIX_RD1, ST_MIX_RD2});
            sram_dq_oe <= state_d inside {ST_REC_WR, ST_MIX_WR};
            sram_we_n  <= !((state_d inside {ST_REC_WR, ST_MIX_WR}) &&
                            (cyc_d != '0) && (cyc_d <= WE_LAST));
            if (state_d != state_q) begin
                case (state_d)
                    ST_REC_WR: begin
                        sram_addr   <= rec_addr;
                        sram_dq_out <= rec_data;
                    end
                    ST_PLAY_RD: sram_addr <= play_addr;
                    ST_MIX_RD1: sram_addr <= mix1_addr;
                    ST_MIX_RD2: sram_addr <= mix2_addr;
                    ST_MIX_WR: begin
                        sram_addr   <= mix1_addr;
                        sram_dq_out <= mix_sample(a_q, sram_dq_in);
                    end
                    default: ;
                endcase
            end
            if ((state_q == ST_MIX_RD1) && last_c)
                a_q <= sram_dq_in;
            rd_pend_q <= play_inc;
            if (play_inc)
                rd_q <= sram_dq_in;
            play_valid <= rd_pend_q;
            if (rd_pend_q)
                play_data <= rd_q;
            mix_done <= mix_inc && mix_last;
            if (mix_accept)
                mix_busy <= 1'b1;
            else if (mix_inc && mix_last)
                mix_busy <= 1'b0;
            if (frame_tick && (state_q != ST_IDLE))
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_track_scheduler.sv
// Randomised scoreboard bench for sram_track_scheduler with a small track geometry and an SRAM model.
module tb_sram_track_scheduler;

    localparam int unsigned AW  = 18;
    localparam int unsigned DW  = 16;
    localparam int unsigned LEN = 8;
    localparam int unsigned T1  = 0;
    localparam int unsigned T2  = 16;
    localparam int unsigned ACC = 3;
`ifdef MIX_SAT_EN
    localparam logic [15:0] MIX0_EXP = 16'h7FFF;
`else
    localparam logic [15:0] MIX0_EXP = 16'h4000;
`endif

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          AUD_DACLRCK, frame_tick, rec_en, rec_sel, play_en, play_sel, mix_start;
    logic [DW-1:0] rec_data, play_data, sram_dq_out, sram_dq_in;
    logic          play_valid, mix_busy, mix_done, overrun, sram_dq_oe, sram_we_n, sram_oe_n;
    logic [AW-1:0] sram_addr;

    sram_track_scheduler #(
        .ADDR_W(AW), .DATA_W(DW), .TRACK_LEN(LEN),
        .TRACK1_BASE(T1), .TRACK2_BASE(T2), .ACC_CYC(ACC)
    ) dut (
        .clk(clk), .AUD_DACLRCK(AUD_DACLRCK), .frame_tick(frame_tick),
        .rec_en(rec_en), .rec_sel(rec_sel), .rec_data(rec_data),
        .play_en(play_en), .play_sel(play_sel), .play_data(play_data), .play_valid(play_valid),
        .mix_start(mix_start), .mix_busy(mix_busy), .mix_done(mix_done), .overrun(overrun),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    // SRAM model with a backdoor port for preloading.
    logic [15:0] mem [0:31];
    logic        bd_we = 1'b0;
    logic [4:0]  bd_addr = '0;
    logic [15:0] bd_data = '0;
    always @(posedge clk) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (!sram_we_n && sram_dq_oe)
            mem[sram_addr[4:0]] <= sram_dq_out;
    end
    assign sram_dq_in = mem[sram_addr[4:0]];

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    typedef struct { logic [AW-1:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic [15:0] data; int at; } rd_t;
    wr_t exp_w[$];
    rd_t exp_r[$];
    int  exp_done[$];

    // Reference model state
    logic [15:0] refm [0:31];
    int          rp = 0, pp = 0, idx = 0;
    bit          busy_m = 0, ovr_m = 0;
    logic [15:0] last_play = '0;

    function automatic logic [15:0] ref_mix(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
`ifdef MIX_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`else
        s = s >>> 1;
`endif
        return s[15:0];
    endfunction

    // Monitor: pops the scoreboard whenever the DUT completes a write, a read or a mix.
    initial begin : monitor
        int          wlow;
        logic [AW-1:0] wa;
        logic [15:0] wd;
        wr_t         w;
        rd_t         r;
        wlow = 0;
        wa = '0;
        wd = '0;
        forever begin
            @(negedge clk);
            if (AUD_DACLRCK) begin
                wlow = 0;
            end else begin
                chk("bus_excl", 32'(!sram_we_n && !sram_oe_n), 0);
                if (!sram_we_n) begin
                    wlow++;
                    wa = sram_addr;
                    wd = sram_dq_out;
                    chk("wr_dq_oe", 32'(sram_dq_oe), 1);
                end else if (wlow != 0) begin
                    if (exp_w.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL wr_unexpected: write addr 0x%0h data 0x%0h, none expected", wa, wd);
                    end else begin
                        w = exp_w.pop_front();
                        chk("wr_addr", 32'(wa), 32'(w.addr));
                        chk("wr_data", 32'(wd), 32'(w.data));
                        chk("wr_we_width", wlow, ACC - 2);
                    end
                    wlow = 0;
                end
                if (play_valid) begin
                    if (exp_r.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rd_unexpected: play_valid with data 0x%0h, none expected", play_data);
                    end else begin
                        r = exp_r.pop_front();
                        chk("rd_data", 32'(play_data), 32'(r.data));
                        chk("rd_latency", cycle, r.at);
                    end
                end
                if (mix_done) begin
                    if (exp_done.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL mix_done_unexpected: pulse at cycle %0d, none expected", cycle);
                    end else begin
                        void'(exp_done.pop_front());
                    end
                end
            end
        end
    end

    task automatic bd(input int a, input logic [15:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 5'(a); bd_data = d;
        refm[a] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic pulse_mix();
        @(negedge clk);
        mix_start = 1'b1;
        if (!busy_m) begin busy_m = 1; idx = 0; end
        @(negedge clk);
        mix_start = 1'b0;
    endtask

    task automatic frame(input logic re, input logic rs, input logic [15:0] rd,
                         input logic pe, input logic ps, input int extra);
        int t, a;
        logic [15:0] w;
        @(negedge clk);
        rec_en = re; rec_sel = rs; rec_data = rd; play_en = pe; play_sel = ps;
        frame_tick = 1'b1;
        t = cycle;
        if (busy_m) begin
            w = ref_mix(refm[T1 + idx], refm[T2 + idx]);
            refm[T1 + idx] = w;
            exp_w.push_back('{addr: AW'(T1 + idx), data: w});
            idx++;
            if (idx == LEN) begin busy_m = 0; idx = 0; exp_done.push_back(t); end
        end else if (re) begin
            a = (rs ? T2 : T1) + rp;
            refm[a] = rd;
            exp_w.push_back('{addr: AW'(a), data: rd});
            rp = (rp + 1) % LEN;
            if (pe) begin
                last_play = refm[(ps ? T2 : T1) + pp];
                exp_r.push_back('{data: last_play, at: t + 2*ACC + 2});
                pp = (pp + 1) % LEN;
            end
        end else if (pe) begin
            last_play = refm[(ps ? T2 : T1) + pp];
            exp_r.push_back('{data: last_play, at: t + ACC + 2});
            pp = (pp + 1) % LEN;
        end
        @(negedge clk);
        frame_tick = 1'b0;
        if (extra > 0) begin
            repeat (extra - 1) @(negedge clk);
            frame_tick = 1'b1;
            ovr_m = 1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
        repeat (3*ACC + 4) @(negedge clk);
        chk("overrun", 32'(overrun), 32'(ovr_m));
        chk("mix_busy", 32'(mix_busy), 32'(busy_m));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        AUD_DACLRCK = 1'b1; frame_tick = 1'b0; rec_en = 1'b0; rec_sel = 1'b0; rec_data = '0;
        play_en = 1'b0; play_sel = 1'b0; mix_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_play_data", 32'(play_data), 0);
        chk("rst_play_valid", 32'(play_valid), 0);
        chk("rst_mix_busy", 32'(mix_busy), 0);
        chk("rst_mix_done", 32'(mix_done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_dq_oe", 32'(sram_dq_oe), 0);
        chk("rst_we_n", 32'(sram_we_n), 1);
        chk("rst_oe_n", 32'(sram_oe_n), 1);
        @(negedge clk);
        AUD_DACLRCK = 1'b0;
        for (int i = 0; i < 32; i++) bd(i, 16'($urandom));

        frame(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 0);
        bd(T2, 16'hBEEF);
        frame(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        chk("play_beef", 32'(play_data), 32'h0000BEEF);
        frame(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2);

        bd(T1, 16'h7FFF);
        bd(T2, 16'h0001);
        pulse_mix();
        for (int i = 0; i < LEN; i++) begin
            if (i == 3) pulse_mix();
            frame(1'b1, 1'($urandom), 16'($urandom), 1'b1, 1'($urandom), 0);
        end
        chk("mix_word0", 32'(mem[T1]), 32'(MIX0_EXP));
        chk("play_hold", 32'(play_data), 32'(last_play));

        for (int i = 0; i < LEN + 1; i++)
            frame(1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 11) == 0) pulse_mix();
            frame(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        for (int i = 0; i < LEN + 1 && busy_m; i++)
            frame(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0);

        // Reset asserted while the write strobe is low must free the bus at once.
        @(negedge clk);
        rec_en = 1'b1; rec_sel = 1'b0; rec_data = 16'hA5A5; play_en = 1'b0; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int i = 0; i < 8 && sram_we_n; i++) @(negedge clk);
        chk("rst_mid_we_low_seen", 32'(sram_we_n), 0);
        #2 AUD_DACLRCK = 1'b1;
        #1;
        chk("rst_mid_we_n", 32'(sram_we_n), 1);
        chk("rst_mid_dq_oe", 32'(sram_dq_oe), 0);
        chk("rst_mid_oe_n", 32'(sram_oe_n), 1);
        chk("rst_mid_addr", 32'(sram_addr), 0);
        chk("rst_mid_play_data", 32'(play_data), 0);
        chk("rst_mid_overrun", 32'(overrun), 0);
        chk("rst_mid_mix_busy", 32'(mix_busy), 0);
        repeat (2) @(negedge clk);
        AUD_DACLRCK = 1'b0;
        rec_en = 1'b0;
        rp = 0; pp = 0; idx = 0; busy_m = 0; ovr_m = 0;
        frame(1'b1, 1'b0, 16'($urandom), 1'b1, 1'b1, 0);

        chk("wr_queue_drained", exp_w.size(), 0);
        chk("rd_queue_drained", exp_r.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
